// File: rtl/cam_pkg.sv
// Shared types and width helpers for the CAM match encoder.
package cam_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } cam_state_e;

    // Width of an encoded entry index (at least one bit).
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Width able to hold a popcount from 0 up to w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cam_prio_pick.sv
// Combinational priority pick: selects the lowest or highest set bit of a vector.
module cam_prio_pick
    import cam_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [WIDTH-1:0]        vec_i,
    output logic [idx_w(WIDTH)-1:0] idx_o,
    output logic [WIDTH-1:0]        onehot_o,
    output logic                    any_o
);

    localparam int IW = idx_w(WIDTH);

    // Scan in priority order; the first set bit found wins.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        any_o    = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            int unsigned pos;
            pos = LSB_FIRST ? k : (WIDTH - 1 - k);
            if (!any_o && vec_i[pos]) begin
                any_o    = 1'b1;
                idx_o    = IW'(pos);
                onehot_o = WIDTH'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/cam_match_encoder.sv
// CAM match encoder: accepts a match vector and streams one beat per set bit.
module cam_match_encoder
    import cam_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_match,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [idx_w(WIDTH)-1:0] out_index,
    output logic                    out_hit,
    output logic                    out_last,
    output logic                    out_multi,
    output logic [cnt_w(WIDTH)-1:0] out_count
);

    localparam int IW = idx_w(WIDTH);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    cam_state_e       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             hit_q, hit_d;
    logic             last_q, last_d;
    logic             multi_q, multi_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CW-1:0]    popcnt;
    logic             out_fire;
    logic             accept;
    logic             load;
    logic [IW-1:0]    pk_idx;
    logic [WIDTH-1:0] pk_onehot;
    logic             pk_any;

    assign out_fire = valid_q & out_ready;
    assign in_ready = (state_q == IDLE) | (out_fire & last_q);
    assign accept   = in_valid & in_ready;

    // Population count of the offered vector.
    always_comb begin
        popcnt = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            popcnt = popcnt + CW'(in_match[k]);
        end
    end

    // Pending-vector and handshake next state.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        multi_d = multi_q;
        load    = 1'b0;
        if (accept) begin
            pend_d  = in_match;
            cnt_d   = popcnt;
            multi_d = (popcnt > CW'(1));
            valid_d = 1'b1;
            state_d = EMIT;
            load    = 1'b1;
        end else if (out_fire) begin
            if (last_q) begin
                pend_d  = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end else begin
                pend_d = pend_q & ~sel_q;
                load   = 1'b1;
            end
        end
    end

    // The beat that will be presented next is picked from the next pending value,
    // so every beat field comes straight out of a register.
    cam_prio_pick #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_pick (
        .vec_i    (pend_d),
        .idx_o    (pk_idx),
        .onehot_o (pk_onehot),
        .any_o    (pk_any)
    );

    // Beat field next state; refreshed only when a new beat is formed.
    always_comb begin
        idx_d  = idx_q;
        sel_d  = sel_q;
        hit_d  = hit_q;
        last_d = last_q;
        if (load) begin
            idx_d  = pk_idx;
            sel_d  = pk_onehot;
            hit_d  = pk_any;
            last_d = ((pend_d & (pend_d - ONE)) == '0);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            last_q  <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            last_q  <= last_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_index = idx_q;
    assign out_hit   = hit_q;
    assign out_last  = last_q;
    assign out_multi = multi_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder (WIDTH=8, both priority orders).
module tb_cam_match_encoder;

    typedef struct packed {
        logic [2:0] idx;
        logic       hit;
        logic       last;
        logic       multi;
        logic [3:0] cnt;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_match = '0;
    logic       out_ready = 1'b0;

    logic       a_ir, a_ov, a_hit, a_last, a_multi;
    logic [2:0] a_idx;
    logic [3:0] a_cnt;
    logic       b_ir, b_ov, b_hit, b_last, b_multi;
    logic [2:0] b_idx;
    logic [3:0] b_cnt;

    int checks = 0;
    int errors = 0;

    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    cam_match_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
        .in_match(in_match), .out_valid(a_ov), .out_ready(out_ready),
        .out_index(a_idx), .out_hit(a_hit), .out_last(a_last),
        .out_multi(a_multi), .out_count(a_cnt)
    );

    cam_match_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
        .in_match(in_match), .out_valid(b_ov), .out_ready(out_ready),
        .out_index(b_idx), .out_hit(b_hit), .out_last(b_last),
        .out_multi(b_multi), .out_count(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // n-th set index of v in the requested order.
    function automatic int nth_index(input logic [7:0] v, input bit lsb, input int n);
        int list[$];
        for (int i = 0; i < 8; i++) if (v[i]) list.push_back(i);
        if (!lsb) list.reverse();
        return (n < list.size()) ? list[n] : -1;
    endfunction

    function automatic void push_beats(input logic [7:0] v);
        int n;
        beat_t b;
        n = $countones(v);
        if (n == 0) begin
            b = '{idx: 3'd0, hit: 1'b0, last: 1'b1, multi: 1'b0, cnt: 4'd0};
            qa.push_back(b);
            qb.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                b.hit   = 1'b1;
                b.last  = (k == n - 1);
                b.multi = (n >= 2);
                b.cnt   = 4'(n);
                b.idx   = 3'(nth_index(v, 1'b1, k));
                qa.push_back(b);
                b.idx   = 3'(nth_index(v, 1'b0, k));
                qb.push_back(b);
            end
        end
    endfunction

    // Per-cycle comparison against the model, then apply the transfers of the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            chk("rst_valid_a", a_ov, 0);
            chk("rst_valid_b", b_ov, 0);
        end else begin
            logic exp_ir;
            exp_ir = (qa.size() == 0) || (qa[0].last && out_ready);
            chk("in_ready_a", a_ir, exp_ir);
            chk("in_ready_b", b_ir, exp_ir);
            chk("valid_a", a_ov, qa.size() != 0);
            chk("valid_b", b_ov, qb.size() != 0);
            if (qa.size() != 0) begin
                chk("index_a", a_idx, qa[0].idx);
                chk("hit_a",   a_hit, qa[0].hit);
                chk("last_a",  a_last, qa[0].last);
                chk("multi_a", a_multi, qa[0].multi);
                chk("count_a", a_cnt, qa[0].cnt);
            end
            if (qb.size() != 0) begin
                chk("index_b", b_idx, qb[0].idx);
                chk("hit_b",   b_hit, qb[0].hit);
                chk("last_b",  b_last, qb[0].last);
                chk("multi_b", b_multi, qb[0].multi);
                chk("count_b", b_cnt, qb[0].cnt);
            end
            if (qa.size() != 0 && out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (in_valid && exp_ir) push_beats(in_match);
        end
    end

    // Holds in_valid/in_match until the DUT accepts; returns just after the accepting edge.
    task automatic send(input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_match = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (a_ir) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("send_timeout", ok, 1);
    endtask

    initial begin
        // Model pins.
        chk("model_24_lsb0", nth_index(8'h24, 1'b1, 0), 2);
        chk("model_24_lsb1", nth_index(8'h24, 1'b1, 1), 5);
        chk("model_24_msb0", nth_index(8'h24, 1'b0, 0), 5);
        chk("model_ff_msb7", nth_index(8'hFF, 1'b0, 7), 0);

        // Reset state.
        #2;
        chk("reset_valid", a_ov, 0);
        chk("reset_index", a_idx, 0);
        chk("reset_hit",   a_hit, 0);
        chk("reset_last",  a_last, 0);
        chk("reset_multi", a_multi, 0);
        chk("reset_count", a_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", a_ir, 1);

        // 8'b0010_0100, both priority orders.
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h24);
        in_valid = 1'b0;
        chk("v24_beat0_idx_a",  a_idx, 2);
        chk("v24_beat0_last_a", a_last, 0);
        chk("v24_beat0_cnt_a",  a_cnt, 2);
        chk("v24_beat0_mul_a",  a_multi, 1);
        chk("v24_beat0_idx_b",  b_idx, 5);
        @(posedge clk); #1;
        chk("v24_beat1_idx_a",  a_idx, 5);
        chk("v24_beat1_last_a", a_last, 1);
        chk("v24_beat1_cnt_a",  a_cnt, 2);
        chk("v24_beat1_mul_a",  a_multi, 1);
        chk("v24_beat1_idx_b",  b_idx, 2);
        @(posedge clk); #1;
        chk("v24_done_valid", a_ov, 0);

        // Empty vector.
        send(8'h00);
        in_valid = 1'b0;
        chk("v00_valid", a_ov, 1);
        chk("v00_hit",   a_hit, 0);
        chk("v00_index", a_idx, 0);
        chk("v00_last",  a_last, 1);
        chk("v00_count", a_cnt, 0);
        chk("v00_multi", a_multi, 0);
        @(posedge clk); #1;
        chk("v00_done_valid", a_ov, 0);

        // Full vector with out_ready toggling.
        send(8'hFF);
        in_valid = 1'b0;
        begin
            int got;
            got = 0;
            for (int c = 0; c < 40 && got < 8; c++) begin
                @(negedge clk);
                if (a_ov && out_ready) begin
                    chk("vff_order", a_idx, got);
                    chk("vff_count", a_cnt, 8);
                    got++;
                end
                @(posedge clk); #1;
                out_ready = ~out_ready;
            end
            chk("vff_beats", got, 8);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back 8'h01 then 8'h80.
        send(8'h01);
        in_match = 8'h80;
        chk("b2b_first_idx",  a_idx, 0);
        chk("b2b_first_last", a_last, 1);
        chk("b2b_ready",      a_ir, 1);
        send(8'h80);
        in_valid = 1'b0;
        chk("b2b_second_valid", a_ov, 1);
        chk("b2b_second_idx",   a_idx, 7);
        @(posedge clk); #1;

        // Reset during the third beat of 8'hFF.
        send(8'hFF);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_third_idx", a_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_valid_a", a_ov, 0);
        chk("abort_valid_b", b_ov, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("abort_idle", a_ov, 0);
        end
        @(posedge clk); #1;

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 5))
                0:       in_match = 8'h00;
                1:       in_match = 8'hFF;
                2:       in_match = 8'(1 << $urandom_range(0, 7));
                default: in_match = 8'($urandom);
            endcase
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("drain_valid", a_ov, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
